// File: rtl/onestate_step_counter.sv
// Single-register step counter under a 3-state FSM (IDLE/RUN/DONE) with load/start/stop.
// Define ONESTATE_SAT_EN to saturate at LIMIT and enter DONE instead of wrapping.
module onestate_step_counter #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int LIMIT = 2**WIDTH-1,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             __in0,
  input  logic             __in1,
  input  logic             __in2,
  input  logic [WIDTH-1:0] __in3,
  output logic [WIDTH-1:0] __out0,
  output logic             __out1,
  output logic             __out2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Arithmetic is done one bit wider so count+STEP never overflows silently.
  localparam logic [WIDTH:0]   LIMIT_X  = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MODULO_X = (WIDTH+1)'(LIMIT + 1);
  localparam logic [WIDTH-1:0] LIMIT_W  = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             flag_reg, flag_next;

  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   wrap_x;
  logic [WIDTH-1:0] load_val;

  assign sum_x    = {1'b0, count_reg} + STEP_X;
  assign wrap_x   = sum_x - MODULO_X;
  assign load_val = ({1'b0, __in3} > LIMIT_X) ? LIMIT_W : __in3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      count_reg <= INIT_W;
      flag_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      flag_reg  <= flag_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    flag_next  = 1'b0;

    if (__in2) begin
      count_next = load_val;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!__in1 && __in0) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (__in1) begin
            state_next = IDLE;
          end else if (sum_x <= LIMIT_X) begin
            count_next = sum_x[WIDTH-1:0];
          end else begin
`ifdef ONESTATE_SAT_EN
            count_next = LIMIT_W;
            state_next = DONE;
            flag_next  = 1'b1;
`else
            count_next = wrap_x[WIDTH-1:0];
            flag_next  = 1'b1;
`endif
          end
        end
        DONE: begin
          // Done level persists until a start (or the load above) clears it.
          flag_next = 1'b1;
          if (!__in1 && __in0) begin
            state_next = RUN;
            count_next = '0;
            flag_next  = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign __out0 = count_reg;
  assign __out1 = flag_reg;
  assign __out2 = (state_reg == RUN);

endmodule

// File: tb/tb_onestate_step_counter.sv
// Directed scoreboard bench for onestate_step_counter (WIDTH=8, STEP=3, LIMIT=250, INIT=5).
module tb_onestate_step_counter;

  logic       clk;
  logic       rst;
  logic       start, stop, load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       flag;
  logic       busy;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    string      tag;
    logic [7:0] count;
    logic       flag;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  onestate_step_counter #(
    .WIDTH(8), .STEP(3), .LIMIT(250), .INIT(5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .__in0  (start),
    .__in1  (stop),
    .__in2  (load),
    .__in3  (load_value),
    .__out0 (count),
    .__out1 (flag),
    .__out2 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic compare_head();
    exp_t e;
    e = exp_q.pop_front();
    checks_total++;
    assert (count === e.count) checks_passed++;
    else $error("FAIL %s count: got %0d expected %0d", e.tag, count, e.count);
    checks_total++;
    assert (flag === e.flag) checks_passed++;
    else $error("FAIL %s out1: got %0b expected %0b", e.tag, flag, e.flag);
    checks_total++;
    assert (busy === e.busy) checks_passed++;
    else $error("FAIL %s busy: got %0b expected %0b", e.tag, busy, e.busy);
    $display("%s: count=%0d out1=%0b busy=%0b", e.tag, count, flag, busy);
  endtask

  // Drive controls, clock one edge, then compare outputs against the pushed expectation.
  task automatic step(input string tag, input logic st, input logic sp, input logic ld,
                      input logic [7:0] val, input logic [7:0] ec, input logic ef,
                      input logic eb);
    exp_t e;
    start = st; stop = sp; load = ld; load_value = val;
    e.tag = tag; e.count = ec; e.flag = ef; e.busy = eb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; load = 1'b0; load_value = 8'd0;
    compare_head();
  endtask

  task automatic check_now(input string tag, input logic [7:0] ec, input logic ef,
                           input logic eb);
    exp_t e;
    e.tag = tag; e.count = ec; e.flag = ef; e.busy = eb;
    exp_q.push_back(e);
    compare_head();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; load_value = 8'd0;
    @(posedge clk); @(posedge clk); #1;
    check_now("reset", 8'd5, 1'b0, 1'b0);
    rst = 1'b1;
    step("idle_hold0", 0, 0, 0, 8'd0, 8'd5, 0, 0);
    step("idle_hold1", 0, 0, 0, 8'd0, 8'd5, 0, 0);
    step("idle_stop_ignored", 0, 1, 0, 8'd0, 8'd5, 0, 0);

    step("start", 1, 0, 0, 8'd0, 8'd5, 0, 1);
    step("inc1", 0, 0, 0, 8'd0, 8'd8, 0, 1);
    step("inc2_start_ignored", 1, 0, 0, 8'd0, 8'd11, 0, 1);
    step("inc3", 0, 0, 0, 8'd0, 8'd14, 0, 1);
    step("inc4", 0, 0, 0, 8'd0, 8'd17, 0, 1);
    step("stop", 0, 1, 0, 8'd0, 8'd17, 0, 0);
    step("stopped_hold", 0, 0, 0, 8'd0, 8'd17, 0, 0);

`ifdef ONESTATE_SAT_EN
    step("sat_load249", 0, 0, 1, 8'd249, 8'd249, 0, 0);
    step("sat_start", 1, 0, 0, 8'd0, 8'd249, 0, 1);
    step("sat_overflow", 0, 0, 0, 8'd0, 8'd250, 1, 0);
    step("sat_done_hold", 0, 0, 0, 8'd0, 8'd250, 1, 0);
    step("sat_restart", 1, 0, 0, 8'd0, 8'd0, 0, 1);
    step("sat_inc", 0, 0, 0, 8'd0, 8'd3, 0, 1);
    step("sat_stop", 0, 1, 0, 8'd0, 8'd3, 0, 0);
`else
    step("wrap_load249", 0, 0, 1, 8'd249, 8'd249, 0, 0);
    step("wrap_start", 1, 0, 0, 8'd0, 8'd249, 0, 1);
    step("wrap_pulse", 0, 0, 0, 8'd0, 8'd1, 1, 1);
    step("wrap_after", 0, 0, 0, 8'd0, 8'd4, 0, 1);
    step("wrap_stop", 0, 1, 0, 8'd0, 8'd4, 0, 0);
    step("edge_load247", 0, 0, 1, 8'd247, 8'd247, 0, 0);
    step("edge_start", 1, 0, 0, 8'd0, 8'd247, 0, 1);
    step("edge_reach_limit", 0, 0, 0, 8'd0, 8'd250, 0, 1);
    step("edge_wrap", 0, 0, 0, 8'd0, 8'd2, 1, 1);
    step("edge_stop", 0, 1, 0, 8'd0, 8'd2, 0, 0);
`endif

    step("load_clamp", 0, 0, 1, 8'd255, 8'd250, 0, 0);
    step("clamp_start", 1, 0, 0, 8'd0, 8'd250, 0, 1);
    step("load_beats_all", 1, 1, 1, 8'd7, 8'd7, 0, 0);
    step("start_stop_idle", 1, 1, 0, 8'd0, 8'd7, 0, 0);

    step("pre_load97", 0, 0, 1, 8'd97, 8'd97, 0, 0);
    step("pre_start", 1, 0, 0, 8'd0, 8'd97, 0, 1);
    step("pre_inc", 0, 0, 0, 8'd0, 8'd100, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_now("async_reset", 8'd5, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_now("reset_held", 8'd5, 1'b0, 1'b0);
    rst = 1'b1;
    step("post_reset_idle", 0, 0, 0, 8'd0, 8'd5, 0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
